// File: rtl/hoaa_pkg.sv
// hoaa_pkg: shared state encoding, default sizes and the HOAA/exact single-bit add rule
package hoaa_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int APPROX_BITS_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [1:0] hoaa_bit(input logic a, input logic b, input logic c, input logic approx);
    logic ac;
    ac = a | c;
    return approx ? {ac & b, ac ^ b} : {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction
endpackage

// File: rtl/hoaa_serial_adder_bit_cell.sv
// hoaa_bit_cell: combinational one-bit adder, approximate HOAA rule when approx=1, exact full-add otherwise
module hoaa_bit_cell
  import hoaa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic approx,
  output logic s,
  output logic co
);
  assign {co, s} = hoaa_bit(a, b, c, approx);
endmodule

// File: rtl/hoaa_serial_adder.sv
// hoaa_serial_adder: bit-serial LSB-first hybrid approximate adder; HOAA_ERR_CHECK_EN adds err_out vs an exact reference
module hoaa_serial_adder
  import hoaa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef HOAA_ERR_CHECK_EN
  ,
  output logic             err_out
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] AB = CW'(APPROX_BITS);
  state_t state, nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0] cnt;
  logic carry, cout_q, s, co, approx, last, accept;
  assign accept = state == IDLE && in_valid;
  assign last = cnt == LAST;
  assign approx = cnt < AB;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sum_out = sum_q;
  assign cout_out = cout_q;
  hoaa_bit_cell u_cell (
    .a(a_q[0]),
    .b(b_q[0]),
    .c(carry),
    .approx(approx),
    .s(s),
    .co(co)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: accept in IDLE, WIDTH bit steps in RUN, hold DONE until hand-off
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  end
  // operand shift registers, carry, bit counter and result assembly (result shifts in from the MSB side)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
      carry <= cin_in;
      cnt <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      sum_q <= {s, sum_q[WIDTH-1:1]};
      carry <= co;
      cnt <= cnt + 1'b1;
      if (last) cout_q <= co;
    end
`ifdef HOAA_ERR_CHECK_EN
  logic [WIDTH:0] exact_q;
  logic err_q;
  assign err_out = err_q;
  // exact reference captured at acceptance; error flag set on entry to DONE, cleared on leaving it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exact_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) exact_q <= {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin_in};
      if (state == RUN && last) err_q <= {co, s, sum_q[WIDTH-1:1]} != exact_q;
      else if (state == DONE && out_ready) err_q <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_hoaa_serial_adder.sv
// tb_hoaa_serial_adder: scoreboard bench for the hybrid (APPROX_BITS=4) and fully exact (APPROX_BITS=0) builds
module tb_hoaa_serial_adder;
  localparam int W = 8;
  typedef struct packed {logic [W:0] res; logic err;} exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 1, cin_in = 0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic in_ready, out_valid, cout_out;
  logic [W-1:0] sum_out;
  logic v0 = 0, r0 = 1, c0 = 0;
  logic [W-1:0] a0 = '0, b0 = '0;
  logic rdy0, ov0, co0;
  logic [W-1:0] s0;
`ifdef HOAA_ERR_CHECK_EN
  logic err_out, err0;
`endif
  int checks = 0, passed = 0, cyc = 0, acc_cyc = 0, seen = 0;
  logic pov = 0;
  exp_t q[$], q0[$];
  exp_t e, e0;
  hoaa_serial_adder #(.WIDTH(W), .APPROX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .cout_out(cout_out)
`ifdef HOAA_ERR_CHECK_EN
    , .err_out(err_out)
`endif
  );
  hoaa_serial_adder #(.WIDTH(W), .APPROX_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .a_in(a0), .b_in(b0), .cin_in(c0), .out_valid(ov0),
    .out_ready(r0), .sum_out(s0), .cout_out(co0)
`ifdef HOAA_ERR_CHECK_EN
    , .err_out(err0)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) acc_cyc = cyc;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !pov) chk("latency", cyc - acc_cyc, 8);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", {cout_out, sum_out}, e.res);
`ifdef HOAA_ERR_CHECK_EN
          chk("err", err_out, e.err);
`endif
        end
      end
      if (ov0 && r0) begin
        if (q0.size() == 0) chk("unexpected_result0", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("exact_result", {co0, s0}, e0.res);
`ifdef HOAA_ERR_CHECK_EN
          chk("exact_err", err0, e0.err);
`endif
        end
      end
    end
    pov = out_valid;
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W:0] res, input logic er, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    if (push) q.push_back('{res, er});
    a_in = a; b_in = b; cin_in = c; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    while (!rdy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready0_wait", rdy0, 1);
    q0.push_back('{{1'b0, a} + {1'b0, b} + {{W{1'b0}}, c}, 1'b0});
    a0 = a; b0 = b; c0 = c; v0 = 1;
    @(posedge clk); #1;
    v0 = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size() + q0.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", {cout_out, sum_out}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    send(8'h0F, 8'h01, 0, 9'h00E, 1, 1);
    send(8'h01, 8'h01, 1, 9'h002, 1, 1);
    send(8'hF0, 8'h10, 0, 9'h100, 0, 1);
    send(8'hFF, 8'hFF, 1, 9'h1F0, 1, 1);
    send(8'h00, 8'h00, 1, 9'h001, 0, 1);
    send(8'h0A, 8'h05, 0, 9'h00F, 0, 1);
    drain();
    out_ready = 0;
    send(8'h3C, 8'h0C, 0, 9'h040, 1, 1);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("stall_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      a_in = 8'hAA; b_in = 8'h55; cin_in = 1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum", {cout_out, sum_out}, 9'h040);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_handoff_in_ready", in_ready, 1);
    chk("post_handoff_out_valid", out_valid, 0);
    chk("idle_holds_sum", sum_out, 8'h40);
    send(8'h0F, 8'h01, 0, 9'h00E, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", {cout_out, sum_out}, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort_release_in_ready", in_ready, 1);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    send(8'h01, 8'h01, 1, 9'h002, 1, 1);
    drain();
    send0(8'hFF, 8'hFF, 1);
    send0(8'h00, 8'h00, 0);
    for (int i = 0; i < 8; i++) send0(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
